// File: rtl/data_mem_requester.sv
// data_mem_requester: single-outstanding load/store sequencer for a 16-bit big-endian data memory,
// adding byte stores via read-modify-write, byte loads with optional sign extension and misalignment errors.
module data_mem_requester #(
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_wr_i,
    input  logic                  req_byte_i,
    input  logic                  req_sext_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [15:0]           req_wdata_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [15:0]           resp_rdata_o,
    output logic                  resp_err_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_enable_o,
    output logic                  mem_wr_o,
    output logic [15:0]           mem_wdata_o,
    input  logic [15:0]           mem_rdata_i
);
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t                state_q, state_d;
    logic                  wr_q, wr_d, byte_q, byte_d, sext_q, sext_d, err_q, err_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           wdata_q, wdata_d, word_q, word_d;
    logic [7:0]            lane;
    logic [15:0]           load_data, merged;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            byte_q  <= 1'b0;
            sext_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            byte_q  <= byte_d;
            sext_q  <= sext_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            word_q  <= word_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        byte_d  = byte_q;
        sext_d  = sext_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        word_d  = word_q;
        case (state_q)
            IDLE: if (req_valid_i && req_ready_o) begin
                wr_d    = req_wr_i;
                byte_d  = req_byte_i;
                sext_d  = req_sext_i;
                addr_d  = req_addr_i;
                wdata_d = req_wdata_i;
                word_d  = '0;
                err_d   = ~req_byte_i & req_addr_i[0];
                state_d = err_d ? RESP : (req_wr_i && !req_byte_i) ? WR : RD;
            end
            RD: begin
                word_d  = mem_rdata_i;
                state_d = wr_q ? WR : RESP;
            end
            WR:   state_d = RESP;
            RESP: state_d = resp_ready_i ? IDLE : RESP;
        endcase
    end

    // Big-endian lanes: even address is the high byte.
    assign lane      = addr_q[0] ? word_q[7:0] : word_q[15:8];
    assign load_data = byte_q ? {{8{sext_q & lane[7]}}, lane} : word_q;
    assign merged    = addr_q[0] ? {word_q[15:8], wdata_q[7:0]} : {wdata_q[7:0], word_q[7:0]};

    // Everything visible is gated by ~rst so a reset cycle can never write memory.
    assign req_ready_o  = ~rst & (state_q == IDLE);
    assign mem_enable_o = ~rst & (state_q == RD || state_q == WR);
    assign mem_wr_o     = ~rst & (state_q == WR);
    assign mem_addr_o   = mem_enable_o ? {addr_q[ADDR_WIDTH-1:1], 1'b0} : '0;
    assign mem_wdata_o  = mem_wr_o ? (byte_q ? merged : wdata_q) : '0;
    assign resp_valid_o = ~rst & (state_q == RESP);
    assign resp_rdata_o = (resp_valid_o && !wr_q) ? load_data : '0;
    assign resp_err_o   = resp_valid_o & err_q;
endmodule

// File: tb/tb_data_mem_requester.sv
// tb_data_mem_requester: directed scoreboard bench for data_mem_requester against a behavioural 16-bit memory.
module tb_data_mem_requester;
    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_wr = 1'b0, req_byte = 1'b0, req_sext = 1'b0;
    logic [15:0] req_addr = '0, req_wdata = '0;
    logic        resp_valid, resp_ready = 1'b1, resp_err;
    logic [15:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_enable, mem_wr;

    typedef struct packed {logic [15:0] rdata; logic err;} exp_t;
    exp_t sb[$];

    logic [15:0] mem [0:32767];
    int          en_cyc = 0, wr_cyc = 0, viol = 0;
    logic [15:0] last_wa = '0;
    int          passed = 0, failed = 0, total = 0;

    data_mem_requester #(.ADDR_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_wr_i(req_wr), .req_byte_i(req_byte),
        .req_sext_i(req_sext), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
        .mem_addr_o(mem_addr), .mem_enable_o(mem_enable), .mem_wr_o(mem_wr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[15:1]];

    always @(posedge clk) begin
        if (mem_enable && mem_wr) mem[mem_addr[15:1]] <= mem_wdata;
        if (mem_enable) en_cyc <= en_cyc + 1;
        if (mem_wr) begin
            wr_cyc  <= wr_cyc + 1;
            last_wa <= mem_addr;
        end
        if ((mem_wr && !mem_enable) || (mem_enable && mem_addr[0]) || (rst && (mem_enable || mem_wr)))
            viol <= viol + 1;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic wr, input logic byt, input logic sx, input logic [15:0] a,
                       input logic [15:0] wd, input logic [15:0] er, input logic ee,
                       input int lat_exp, input int hold);
        int          lat;
        exp_t        e;
        logic [15:0] snap;
        sb.push_back('{er, ee});
        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_wr = wr; req_byte = byt; req_sext = sx; req_addr = a; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        req_wr = 1'($urandom); req_byte = 1'($urandom); req_sext = 1'($urandom);
        req_addr = 16'($urandom); req_wdata = 16'($urandom);
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, lat_exp);
        e = sb.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", resp_err, e.err);
        if (hold > 0) begin
            snap = resp_rdata;
            repeat (hold) begin
                @(negedge clk);
                chk("hold_valid", resp_valid, 1);
                chk("hold_rdata", resp_rdata, snap);
                chk("hold_req_ready", req_ready, 0);
            end
            resp_ready = 1'b1;
        end
        @(negedge clk);
        chk("resp_drop", resp_valid, 0);
    endtask

    initial begin
        int e0, w0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_req_ready", req_ready, 0);
            chk("rst_ctrl", {resp_valid, resp_err, mem_enable, mem_wr}, 0);
            chk("rst_rdata", resp_rdata, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", req_ready, 1);

        w0 = wr_cyc;
        req(1, 0, 0, 16'h0010, 16'hBEEF, 16'h0000, 0, 2, 0);
        chk("word_st_wr_cycles", wr_cyc - w0, 1);
        chk("word_st_addr", last_wa, 16'h0010);
        req(0, 0, 0, 16'h0010, 16'h0000, 16'hBEEF, 0, 2, 0);

        req(1, 0, 0, 16'h0020, 16'h1234, 16'h0000, 0, 2, 0);
        e0 = en_cyc; w0 = wr_cyc;
        req(1, 1, 0, 16'h0021, 16'h55AB, 16'h0000, 0, 3, 0);
        chk("rmw_en_cycles", en_cyc - e0, 2);
        chk("rmw_wr_cycles", wr_cyc - w0, 1);
        chk("rmw_addr", last_wa, 16'h0020);
        req(0, 0, 0, 16'h0020, 16'h0000, 16'h12AB, 0, 2, 0);
        req(1, 1, 0, 16'h0020, 16'h99CD, 16'h0000, 0, 3, 0);
        req(0, 0, 0, 16'h0020, 16'h0000, 16'hCDAB, 0, 2, 0);

        req(1, 0, 0, 16'h0030, 16'h80F0, 16'h0000, 0, 2, 0);
        req(0, 1, 1, 16'h0030, 16'h0000, 16'hFF80, 0, 2, 0);
        req(0, 1, 0, 16'h0030, 16'h0000, 16'h0080, 0, 2, 0);
        req(0, 1, 0, 16'h0031, 16'h0000, 16'h00F0, 0, 2, 0);
        req(0, 1, 1, 16'h0031, 16'h0000, 16'hFFF0, 0, 2, 0);

        req(1, 0, 0, 16'h0040, 16'h1111, 16'h0000, 0, 2, 0);
        e0 = en_cyc;
        req(0, 0, 0, 16'h0041, 16'h0000, 16'h0000, 1, 1, 0);
        req(1, 0, 0, 16'h0041, 16'hDEAD, 16'h0000, 1, 1, 0);
        chk("misalign_no_enable", en_cyc - e0, 0);
        req(0, 0, 0, 16'h0040, 16'h0000, 16'h1111, 0, 2, 0);

        req(1, 0, 0, 16'hFFFE, 16'hA5C3, 16'h0000, 0, 2, 0);
        req(0, 1, 0, 16'hFFFF, 16'h0000, 16'h00C3, 0, 2, 0);
        req(0, 1, 1, 16'hFFFE, 16'h0000, 16'hFFA5, 0, 2, 0);

        resp_ready = 1'b0;
        req(0, 0, 0, 16'h0010, 16'h0000, 16'hBEEF, 0, 2, 5);

        req(1, 0, 0, 16'h0050, 16'h5555, 16'h0000, 0, 2, 0);
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b1; req_byte = 1'b1; req_sext = 1'b0;
        req_addr = 16'h0051; req_wdata = 16'h0077;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("abort_in_wr", mem_wr, 1);
        w0 = wr_cyc;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_no_write", wr_cyc - w0, 0);
        chk("abort_resp_valid", resp_valid, 0);
        chk("abort_idle_ready", req_ready, 1);
        repeat (2) @(negedge clk);
        chk("abort_no_late_resp", resp_valid, 0);
        req(0, 0, 0, 16'h0050, 16'h0000, 16'h5555, 0, 2, 0);

        chk("protocol_violations", viol, 0);
        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
